// File: rtl/button_gesture_if.sv
// Button gesture event bundle: debounced level in, one-cycle event pulses out.
// The DUT uses the slave modport; whoever drives the button uses master.
interface button_gesture_if;
    logic i_btn;
    logic o_press;
    logic o_release;
    logic o_click;
    logic o_double;
    logic o_long;
    logic o_repeat;

    modport master (
        output i_btn,
        input  o_press, o_release, o_click,
        input  o_double, o_long, o_repeat
    );

    modport slave (
        input  i_btn,
        output o_press, o_release, o_click,
        output o_double, o_long, o_repeat
    );
endinterface

// File: rtl/button_gesture.sv
// Classifies a debounced button level into press/release/click/double/long pulses.
// Optional auto-repeat in HELD is built when BUTTON_GESTURE_REPEAT_EN is defined.
module button_gesture #(
    parameter int LONG_TICKS   = 1000000,
    parameter int DCLICK_TICKS = 300000,
    parameter int REPEAT_TICKS = 200000,
    parameter int TIMER_W      = 24
) (
    input  logic           i_clk,
    input  logic           i_reset_n,
    button_gesture_if.slave gif
);

    localparam longint unsigned TLIM = 64'd1 << TIMER_W;

    if (LONG_TICKS < 2 || 64'(LONG_TICKS) >= TLIM) begin : g_bad_long
        $error("LONG_TICKS out of range for TIMER_W");
    end
    if (DCLICK_TICKS < 2 || 64'(DCLICK_TICKS) >= TLIM) begin : g_bad_dclick
        $error("DCLICK_TICKS out of range for TIMER_W");
    end
    if (REPEAT_TICKS < 2 || 64'(REPEAT_TICKS) >= TLIM) begin : g_bad_repeat
        $error("REPEAT_TICKS out of range for TIMER_W");
    end

    localparam logic [TIMER_W-1:0] LONG_M1   = TIMER_W'(LONG_TICKS - 1);
    localparam logic [TIMER_W-1:0] DCLICK_M1 = TIMER_W'(DCLICK_TICKS - 1);

    typedef enum logic [2:0] {
        IDLE, PRESS1, GAP, PRESS2, HELD
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [TIMER_W-1:0] timer_q;
    logic               r_prev;
    logic               rise;
    logic               fall;
    logic               long_hit;
    logic               dclick_hit;
    logic               rep_hit;

    logic press_d;
    logic release_d;
    logic click_d;
    logic double_d;
    logic long_d;
    logic repeat_d;

    assign rise       = gif.i_btn & ~r_prev;
    assign fall       = ~gif.i_btn & r_prev;
    assign long_hit   = (timer_q == LONG_M1);
    assign dclick_hit = (timer_q == DCLICK_M1);

    // r_prev resets high so a button held through reset is not a press.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            timer_q <= '0;
            r_prev  <= 1'b1;
        end else begin
            state_q <= state_d;
            r_prev  <= gif.i_btn;
            if (state_d != state_q) begin
                timer_q <= '0;
            end else if (timer_q != '1) begin
                timer_q <= timer_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (rise) state_d = PRESS1;
            PRESS1: begin
                if (fall)          state_d = GAP;
                else if (long_hit) state_d = HELD;
            end
            GAP: begin
                if (rise)            state_d = PRESS2;
                else if (dclick_hit) state_d = IDLE;
            end
            PRESS2: begin
                if (fall)          state_d = IDLE;
                else if (long_hit) state_d = HELD;
            end
            HELD:   if (fall) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        press_d   = 1'b0;
        release_d = 1'b0;
        click_d   = 1'b0;
        double_d  = 1'b0;
        long_d    = 1'b0;
        unique case (state_q)
            IDLE:   press_d = rise;
            PRESS1: begin
                if (fall)          release_d = 1'b1;
                else if (long_hit) long_d    = 1'b1;
            end
            GAP: begin
                if (rise)            press_d = 1'b1;
                else if (dclick_hit) click_d = 1'b1;
            end
            PRESS2: begin
                if (fall) begin
                    release_d = 1'b1;
                    double_d  = 1'b1;
                end else if (long_hit) begin
                    click_d = 1'b1;
                    long_d  = 1'b1;
                end
            end
            HELD:   release_d = fall;
            default: ;
        endcase
        repeat_d = rep_hit;
    end

`ifdef BUTTON_GESTURE_REPEAT_EN
    localparam logic [TIMER_W-1:0] REPEAT_M1 = TIMER_W'(REPEAT_TICKS - 1);

    logic [TIMER_W-1:0] rep_q;

    assign rep_hit = (state_q == HELD) && !fall && (rep_q == REPEAT_M1);

    // Zero outside HELD, so it starts fresh on every HELD entry.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n || state_q != HELD) begin
            rep_q <= '0;
        end else if (rep_hit) begin
            rep_q <= '0;
        end else begin
            rep_q <= rep_q + 1'b1;
        end
    end
`else
    assign rep_hit = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            gif.o_press   <= 1'b0;
            gif.o_release <= 1'b0;
            gif.o_click   <= 1'b0;
            gif.o_double  <= 1'b0;
            gif.o_long    <= 1'b0;
            gif.o_repeat  <= 1'b0;
        end else begin
            gif.o_press   <= press_d;
            gif.o_release <= release_d;
            gif.o_click   <= click_d;
            gif.o_double  <= double_d;
            gif.o_long    <= long_d;
            gif.o_repeat  <= repeat_d;
        end
    end

endmodule

// File: tb/tb_button_gesture.sv
// Directed bench for button_gesture: segment table plus reset corner cases.
// Output vector order: {press, release, click, double, long, repeat}.
module tb_button_gesture;

    localparam int LT = 20;
    localparam int DT = 10;
    localparam int RT = 5;

    localparam logic [5:0] N  = 6'b000000;
    localparam logic [5:0] P  = 6'b100000;
    localparam logic [5:0] R  = 6'b010000;
    localparam logic [5:0] C  = 6'b001000;
    localparam logic [5:0] D  = 6'b000100;
    localparam logic [5:0] L  = 6'b000010;
`ifdef BUTTON_GESTURE_REPEAT_EN
    localparam logic [5:0] RP = 6'b000001;
`else
    localparam logic [5:0] RP = 6'b000000;
`endif

    typedef struct {
        string      tag;
        bit         btn;
        int         len;
        logic [5:0] exp;
    } seg_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_step = 0;
    seg_t tbl[$];

    always #5 clk = ~clk;

    button_gesture_if gif ();

    button_gesture #(
        .LONG_TICKS  (LT),
        .DCLICK_TICKS(DT),
        .REPEAT_TICKS(RT),
        .TIMER_W     (24)
    ) dut (
        .i_clk    (clk),
        .i_reset_n(rst_n),
        .gif      (gif)
    );

    // Output seen after an edge is the response to the inputs driven before it.
    task automatic step(input bit rst, input bit btn,
                        input logic [5:0] exp, input string tag);
        logic [5:0] got;
        @(negedge clk);
        rst_n = rst;
        gif.i_btn = btn;
        @(posedge clk);
        #1;
        got = {gif.o_press, gif.o_release, gif.o_click,
               gif.o_double, gif.o_long, gif.o_repeat};
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %b expected %b",
                     tag, n_step, got, exp);
        end
        n_step++;
    endtask

    task automatic seg(input string tag, input bit btn,
                       input int len, input logic [5:0] exp);
        tbl.push_back('{tag, btn, len, exp});
    endtask

    initial begin
        gif.i_btn = 1'b1;

        // held through reset: silent until a fresh press
        seg("held_rst", 1, 30, N);
        seg("held_rst", 0, 5, N);
        seg("single", 1, 1, P);
        seg("single", 1, 2, N);
        seg("single", 0, 1, R);
        seg("single", 0, 9, N);
        seg("single", 0, 1, C);
        seg("single", 0, 3, N);
        // double click, gap of 4
        seg("double", 1, 1, P);
        seg("double", 1, 2, N);
        seg("double", 0, 1, R);
        seg("double", 0, 3, N);
        seg("double", 1, 1, P);
        seg("double", 1, 2, N);
        seg("double", 0, 1, R | D);
        seg("double", 0, 12, N);
        // long press held 25
        seg("long", 1, 1, P);
        seg("long", 1, 19, N);
        seg("long", 1, 1, L);
        seg("long", 1, 4, N);
        seg("long", 0, 1, R);
        seg("long", 0, 12, N);
        // rise on the same edge as the gap timeout
        seg("race", 1, 1, P);
        seg("race", 1, 2, N);
        seg("race", 0, 1, R);
        seg("race", 0, 9, N);
        seg("race", 1, 1, P);
        seg("race", 1, 2, N);
        seg("race", 0, 1, R | D);
        seg("race", 0, 12, N);
        // one cycle too late: two separate clicks
        seg("late", 1, 1, P);
        seg("late", 1, 2, N);
        seg("late", 0, 1, R);
        seg("late", 0, 9, N);
        seg("late", 0, 1, C);
        seg("late", 1, 1, P);
        seg("late", 1, 2, N);
        seg("late", 0, 1, R);
        seg("late", 0, 9, N);
        seg("late", 0, 1, C);
        seg("late", 0, 2, N);
        // hold 36: long at +20, repeats at +25/+30/+35
        seg("repeat", 1, 1, P);
        seg("repeat", 1, 19, N);
        seg("repeat", 1, 1, L);
        seg("repeat", 1, 4, N);
        seg("repeat", 1, 1, RP);
        seg("repeat", 1, 4, N);
        seg("repeat", 1, 1, RP);
        seg("repeat", 1, 4, N);
        seg("repeat", 1, 1, RP);
        seg("repeat", 0, 1, R);
        seg("repeat", 0, 12, N);

        for (int i = 0; i < 3; i++) step(0, 1, N, "reset");

        foreach (tbl[i]) begin
            for (int k = 0; k < tbl[i].len; k++) begin
                step(1, tbl[i].btn, tbl[i].exp, tbl[i].tag);
            end
        end

        // reset dropped mid-gap aborts the pending click
        step(1, 1, P, "gap_rst");
        for (int i = 0; i < 2; i++) step(1, 1, N, "gap_rst");
        step(1, 0, R, "gap_rst");
        for (int i = 0; i < 3; i++) step(1, 0, N, "gap_rst");
        for (int i = 0; i < 2; i++) step(0, 0, N, "gap_rst_in");
        for (int i = 0; i < 15; i++) step(1, 0, N, "gap_rst_after");
        step(1, 1, P, "post_rst");
        for (int i = 0; i < 2; i++) step(1, 1, N, "post_rst");
        step(1, 0, R, "post_rst");
        for (int i = 0; i < 9; i++) step(1, 0, N, "post_rst");
        step(1, 0, C, "post_rst");
        for (int i = 0; i < 2; i++) step(1, 0, N, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
